// File: rtl/spi_slave_regbank_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | spi_slave_regbank_if : frame/data signals of the SPI register bank    |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
interface spi_slave_regbank_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                     CS;
  logic                     MOSI;
  logic [DEPTH*WIDTH-1:0]   regs_flat;
  logic                     wr_pulse;
  logic [ADDR_W-1:0]        wr_addr;

  modport slave (
    input  CS,
    input  MOSI,
    output regs_flat,
    output wr_pulse,
    output wr_addr
  );

  modport master (
    output CS,
    output MOSI,
    input  regs_flat,
    input  wr_pulse,
    input  wr_addr
  );
endinterface
`default_nettype wire

// File: rtl/spi_slave_regbank.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | spi_slave_regbank : SPI mode-0 slave with auto-incrementing reg bank  |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module spi_slave_regbank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire logic           SCLK,
  input  wire logic           rst,
  // MISO stays a plain pin so the pad-level tristate is visible at the top
  output wire                 MISO,
  spi_slave_regbank_if.slave  bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_CMD = 2'd0,
    S_WR  = 2'd1,
    S_RD  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_frst;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [WIDTH-1:0]   r_rx_shift;
  logic [WIDTH-1:0]   r_tx_shift;
  logic [WIDTH-1:0]   w_word;
  logic               w_word_done;
  logic               w_commit;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  w_addr_nxt;
  logic               r_wr_pulse;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [WIDTH-1:0]   r_bank [DEPTH];

  // CS high ends the frame asynchronously, same as a full reset for the frame logic
  assign w_frst = rst | bus.CS;

  always_comb begin
    w_word_done = (r_bit_cnt == C_LAST_BIT);
    w_word      = {r_rx_shift[WIDTH-2:0], bus.MOSI};
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_commit    = 1'b0;
    if (w_word_done) begin
      case (r_state)
        S_CMD: begin
          w_addr_nxt  = w_word[ADDR_W-1:0];
          w_state_nxt = w_word[WIDTH-1] ? S_RD : S_WR;
        end
        S_WR: begin
          w_commit   = 1'b1;
          w_addr_nxt = r_addr + ADDR_W'(1);
        end
        S_RD: begin
          w_addr_nxt = r_addr + ADDR_W'(1);
        end
        default: begin
          w_state_nxt = S_CMD;
        end
      endcase
    end
  end

  always_ff @(posedge SCLK or posedge w_frst) begin
    if (w_frst) begin
      r_state    <= S_CMD;
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_wr_pulse <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_word_done ? '0 : r_bit_cnt + CNT_W'(1);
      r_rx_shift <= w_word;
      r_wr_pulse <= w_commit;
    end
  end

  // Bank and address survive CS; only the global reset clears them
  always_ff @(posedge SCLK or posedge rst) begin
    if (rst) begin
      r_addr    <= '0;
      r_wr_addr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_bank[i] <= '0;
      end
    end else if (!bus.CS) begin
      r_addr <= w_addr_nxt;
      if (w_commit) begin
        r_bank[r_addr] <= w_word;
        r_wr_addr      <= r_addr;
      end
    end
  end

  // Load on the falling edge after a word boundary so the MSB is ready before the next rise
  always_ff @(negedge SCLK or posedge w_frst) begin
    if (w_frst) begin
      r_tx_shift <= '0;
    end else if (r_state == S_RD && r_bit_cnt == '0) begin
      r_tx_shift <= r_bank[r_addr];
    end else begin
      r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};
    end
  end

  assign MISO = w_frst ? 1'bz : r_tx_shift[WIDTH-1];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
      assign bus.regs_flat[gi*WIDTH +: WIDTH] = r_bank[gi];
    end
  endgenerate

  assign bus.wr_pulse = r_wr_pulse;
  assign bus.wr_addr  = r_wr_addr;
endmodule
`default_nettype wire

// File: tb/tb_spi_slave_regbank.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_spi_slave_regbank : directed scoreboard bench for the SPI reg bank |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module tb_spi_slave_regbank;
  logic SCLK;
  logic rst;
  wire  MISO;

  spi_slave_regbank_if #(.WIDTH(8), .DEPTH(4)) bus ();

  spi_slave_regbank #(.WIDTH(8), .DEPTH(4)) dut (
    .SCLK (SCLK),
    .rst  (rst),
    .MISO (MISO),
    .bus  (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   pulse_cnt = 0;
  int   pulse_ref;
  logic [7:0] rx;

  always @(posedge bus.wr_pulse) pulse_cnt++;

  function automatic void sb_push(string tag, logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endfunction

  task automatic sb_check(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $error("FAIL sb_empty: observed %0h, required a queued expectation", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val)
      else begin
        n_errors++;
        $error("FAIL %s: observed %0h, required %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic sclk_cycle();
    #5 SCLK = 1'b1;
    #5 SCLK = 1'b0;
  endtask

  // MSB-first transfer of nbits; MISO sampled just before each rising edge
  task automatic xfer(input logic [7:0] w, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.MOSI = w[i];
      #2 r[i] = MISO;
      #3 SCLK = 1'b1;
      #5 SCLK = 1'b0;
    end
  endtask

  task automatic cs_fall();
    bus.CS = 1'b0;
    #5;
  endtask

  task automatic cs_rise();
    #5 bus.CS = 1'b1;
    #10;
  endtask

  initial begin
    SCLK     = 1'b0;
    rst      = 1'b1;
    bus.CS   = 1'b1;
    bus.MOSI = 1'b0;
    #20;
    sb_push("rst_regs", 32'h0);      sb_check(bus.regs_flat);
    sb_push("rst_pulse", 32'h0);     sb_check({31'h0, bus.wr_pulse});
    sb_push("rst_wr_addr", 32'h0);   sb_check({30'h0, bus.wr_addr});
    rst = 1'b0;
    #10;

    // single write, pulse lasts exactly one SCLK period
    pulse_ref = pulse_cnt;
    cs_fall();
    xfer(8'h02, 8, rx);
    xfer(8'hA5, 8, rx);
    #2;
    sb_push("w1_pulse_hi", 32'h1);   sb_check({31'h0, bus.wr_pulse});
    sb_push("w1_wr_addr", 32'h2);    sb_check({30'h0, bus.wr_addr});
    sclk_cycle();
    #2;
    sb_push("w1_pulse_lo", 32'h0);   sb_check({31'h0, bus.wr_pulse});
    cs_rise();
    sb_push("w1_regs", 32'h00A5_0000); sb_check(bus.regs_flat);
    sb_push("w1_npulse", 32'd1);     sb_check(pulse_cnt - pulse_ref);

    // burst write wrapping 3 -> 0
    pulse_ref = pulse_cnt;
    cs_fall();
    xfer(8'h03, 8, rx);
    xfer(8'h11, 8, rx);
    xfer(8'h22, 8, rx);
    cs_rise();
    sb_push("w2_regs", 32'h11A5_0022); sb_check(bus.regs_flat);
    sb_push("w2_npulse", 32'd2);     sb_check(pulse_cnt - pulse_ref);
    sb_push("w2_wr_addr", 32'h0);    sb_check({30'h0, bus.wr_addr});

    // preload then burst read
    cs_fall();
    xfer(8'h01, 8, rx);
    xfer(8'h3C, 8, rx);
    xfer(8'hC3, 8, rx);
    cs_rise();
    sb_push("rd_byte0", 32'h00);
    sb_push("rd_byte1", 32'h3C);
    sb_push("rd_byte2", 32'hC3);
    cs_fall();
    xfer(8'h81, 8, rx); sb_check({24'h0, rx});
    xfer(8'h00, 8, rx); sb_check({24'h0, rx});
    xfer(8'h00, 8, rx); sb_check({24'h0, rx});
    cs_rise();
    sb_push("rd_bank", 32'h11C3_3C22); sb_check(bus.regs_flat);

    // command-only read frame: MSB of reg[2] is driven, then released on CS rise
    cs_fall();
    xfer(8'h82, 8, rx);
    #2;
    sb_push("cmd_only_miso", 32'h1); sb_check({31'h0, MISO});
    cs_rise();
    n_checks++;
    assert (MISO !== 1'b1)
    else begin
      n_errors++;
      $error("FAIL miso_release: observed %b, required z", MISO);
    end
    sb_push("cmd_only_bank", 32'h11C3_3C22); sb_check(bus.regs_flat);

    // partial word is discarded
    pulse_ref = pulse_cnt;
    cs_fall();
    xfer(8'h00, 8, rx);
    xfer(8'hFF, 5, rx);
    cs_rise();
    sb_push("part_bank", 32'h11C3_3C22); sb_check(bus.regs_flat);
    sb_push("part_npulse", 32'd0);   sb_check(pulse_cnt - pulse_ref);
    cs_fall();
    xfer(8'h00, 8, rx);
    xfer(8'h5A, 8, rx);
    cs_rise();
    sb_push("part_next", 32'h11C3_3C5A); sb_check(bus.regs_flat);

    // reset mid-frame, SCLK edges during reset ignored
    cs_fall();
    xfer(8'h02, 8, rx);
    xfer(8'hFF, 3, rx);
    rst = 1'b1;
    #2;
    sb_push("mid_rst_regs", 32'h0);  sb_check(bus.regs_flat);
    sb_push("mid_rst_pulse", 32'h0); sb_check({31'h0, bus.wr_pulse});
    xfer(8'hFF, 8, rx);
    sb_push("in_rst_regs", 32'h0);   sb_check(bus.regs_flat);
    bus.CS = 1'b1;
    #5 rst = 1'b0;
    #10;
    cs_fall();
    xfer(8'h01, 8, rx);
    xfer(8'h77, 8, rx);
    cs_rise();
    sb_push("post_rst", 32'h0000_7700); sb_check(bus.regs_flat);

    // back-to-back read frames separated by one SCLK period of CS high
    cs_fall();
    xfer(8'h03, 8, rx);
    xfer(8'hE1, 8, rx);
    xfer(8'h4B, 8, rx);
    cs_rise();
    sb_push("b2b_a_cmd", 32'h00);
    sb_push("b2b_a_reg0", 32'h4B);
    sb_push("b2b_b_cmd", 32'h00);
    sb_push("b2b_b_reg3", 32'hE1);
    cs_fall();
    xfer(8'h80, 8, rx); sb_check({24'h0, rx});
    xfer(8'h00, 8, rx); sb_check({24'h0, rx});
    bus.CS = 1'b1;
    sclk_cycle();
    bus.CS = 1'b0;
    #5;
    xfer(8'h83, 8, rx); sb_check({24'h0, rx});
    xfer(8'h00, 8, rx); sb_check({24'h0, rx});
    cs_rise();
    sb_push("b2b_bank", 32'hE100_774B); sb_check(bus.regs_flat);

    n_checks++;
    assert (exp_q.size() == 0)
    else begin
      n_errors++;
      $error("FAIL sb_leftover: observed %0d entries, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
